// File: rtl/phase_scheduler.sv
// phase_scheduler: four-approach traffic phase controller.
// Approaches N/E/S/W are served round-robin with min/max green, yellow and
// all-red clearance, all timed in prescaled ticks of TICK_DIV clocks.
// Optional pedestrian WALK phase is built only when PHASE_SCHED_PED_EN is defined.
module phase_scheduler #(
    parameter int TICK_DIV  = 100,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ped_req,
    output logic [7:0] lights,
    output logic [3:0] grant,
    output logic       ped_walk,
    output logic       busy
);

    localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO  = PW'(0);
    localparam logic [8:0]    MIN_G       = 9'(MIN_GREEN);
    localparam logic [8:0]    MAX_G       = 9'(MAX_GREEN);
    localparam logic [8:0]    YEL_G       = 9'(YELLOW_T);
    localparam logic [8:0]    ALLRED_G    = 9'(ALLRED_T);
    localparam logic [1:0]    CODE_GREEN  = 2'b01;
    localparam logic [1:0]    CODE_YELLOW = 2'b10;
    localparam logic [7:0]    ALL_RED     = 8'hFF;
`ifdef PHASE_SCHED_PED_EN
    localparam logic [8:0]    WALK_G      = 9'(WALK_T);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        ALLRED = 3'd3
`ifdef PHASE_SCHED_PED_EN
        ,
        WALK   = 3'd4
`endif
    } state_t;

    // One-hot mask for an approach index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Light word with one approach showing code and every other approach red.
    function automatic logic [7:0] lights_code(input logic [1:0] idx, input logic [1:0] code);
        logic [7:0] v;
        v                     = 8'hFF;
        v[{idx, 1'b0} +: 2]   = code;
        return v;
    endfunction

    state_t        state_r;
    logic [PW-1:0] presc_r;
    logic [7:0]    timer_r;
    logic [3:0]    pending_r;
    logic [1:0]    last_grant_r;
    logic [1:0]    cur_r;
    logic [7:0]    lights_r;
    logic [3:0]    grant_r;
    logic          busy_r;
`ifdef PHASE_SCHED_PED_EN
    logic          ped_pending_r;
    logic          ped_walk_r;
`else
    logic [8:0]    ped_unused_s;
`endif

    logic          tick_s;
    logic [8:0]    timer_inc_s;
    logic [3:0]    green_mask_s;
    logic [3:0]    pend_upd_s;
    logic          green_done_s;
    logic          yellow_done_s;
    logic          release_s;
    logic [3:0]    sel_set_s;
    logic          sel_valid_s;
    logic [1:0]    sel_idx_s;
    logic [1:0]    cand_s;

    // Tick detection, per-state duration compares and demand bookkeeping.
    always_comb begin
        tick_s        = (presc_r == PRESC_LAST);
        timer_inc_s   = {1'b0, timer_r} + 9'd1;
        green_mask_s  = (state_r == GREEN) ? onehot4(cur_r) : 4'b0000;
        pend_upd_s    = pending_r | (req & ~green_mask_s);
        green_done_s  = tick_s && (((timer_inc_s >= MIN_G) && !req[cur_r]) ||
                                   (timer_inc_s >= MAX_G));
        yellow_done_s = tick_s && (timer_inc_s >= YEL_G);
        case (state_r)
            IDLE:    release_s = 1'b1;
            ALLRED:  release_s = tick_s && (timer_inc_s >= ALLRED_G);
`ifdef PHASE_SCHED_PED_EN
            WALK:    release_s = tick_s && (timer_inc_s >= WALK_G);
`endif
            default: release_s = 1'b0;
        endcase
    end

    // Round-robin pick over latched plus same-cycle demand; nearest after last_grant wins.
    always_comb begin
        sel_set_s   = pending_r | req;
        sel_valid_s = |sel_set_s;
        sel_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand_s    = last_grant_r + 2'(k);
            sel_idx_s = sel_set_s[cand_s] ? cand_s : sel_idx_s;
        end
    end

    // Phase state machine: prescaler, phase timer, pending demand and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            presc_r       <= PRESC_ZERO;
            timer_r       <= 8'd0;
            pending_r     <= 4'b0000;
            last_grant_r  <= 2'd3;
            cur_r         <= 2'd0;
            lights_r      <= ALL_RED;
            grant_r       <= 4'b0000;
            busy_r        <= 1'b0;
`ifdef PHASE_SCHED_PED_EN
            ped_pending_r <= 1'b0;
            ped_walk_r    <= 1'b0;
`endif
        end else begin
            pending_r <= pend_upd_s;
            if (tick_s) begin
                presc_r <= PRESC_ZERO;
                timer_r <= timer_r + 8'd1;
            end else begin
                presc_r <= presc_r + PRESC_ONE;
            end
`ifdef PHASE_SCHED_PED_EN
            ped_pending_r <= ped_pending_r | ped_req;
`endif
            case (state_r)
                GREEN: begin
                    if (green_done_s) begin
                        state_r  <= YELLOW;
                        presc_r  <= PRESC_ZERO;
                        timer_r  <= 8'd0;
                        lights_r <= lights_code(cur_r, CODE_YELLOW);
                    end
                end
                YELLOW: begin
                    if (yellow_done_s) begin
                        state_r  <= ALLRED;
                        presc_r  <= PRESC_ZERO;
                        timer_r  <= 8'd0;
                        lights_r <= ALL_RED;
                        grant_r  <= 4'b0000;
                    end
                end
                IDLE, ALLRED
`ifdef PHASE_SCHED_PED_EN
                , WALK
`endif
                : begin
                    if (release_s) begin
                        presc_r <= PRESC_ZERO;
                        timer_r <= 8'd0;
`ifdef PHASE_SCHED_PED_EN
                        if ((state_r == ALLRED) && ped_pending_r) begin
                            state_r       <= WALK;
                            lights_r      <= ALL_RED;
                            grant_r       <= 4'b0000;
                            busy_r        <= 1'b1;
                            ped_walk_r    <= 1'b1;
                            ped_pending_r <= 1'b0;
                        end else
`endif
                        if (sel_valid_s) begin
                            state_r      <= GREEN;
                            cur_r        <= sel_idx_s;
                            last_grant_r <= sel_idx_s;
                            pending_r    <= pend_upd_s & ~onehot4(sel_idx_s);
                            lights_r     <= lights_code(sel_idx_s, CODE_GREEN);
                            grant_r      <= onehot4(sel_idx_s);
                            busy_r       <= 1'b1;
`ifdef PHASE_SCHED_PED_EN
                            ped_walk_r   <= 1'b0;
`endif
                        end else begin
                            state_r    <= IDLE;
                            lights_r   <= ALL_RED;
                            grant_r    <= 4'b0000;
                            busy_r     <= 1'b0;
`ifdef PHASE_SCHED_PED_EN
                            ped_walk_r <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe all-red idle.
                    state_r  <= IDLE;
                    presc_r  <= PRESC_ZERO;
                    timer_r  <= 8'd0;
                    lights_r <= ALL_RED;
                    grant_r  <= 4'b0000;
                    busy_r   <= 1'b0;
`ifdef PHASE_SCHED_PED_EN
                    ped_walk_r <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign lights = lights_r;
    assign grant  = grant_r;
    assign busy   = busy_r;
`ifdef PHASE_SCHED_PED_EN
    assign ped_walk = ped_walk_r;
`else
    assign ped_walk     = 1'b0;
    assign ped_unused_s = {8'(WALK_T), ped_req};
`endif

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed self-checking bench for phase_scheduler with short timing
// parameters (TICK_DIV=4, MIN_GREEN=2, MAX_GREEN=4, YELLOW_T=1, ALLRED_T=1, WALK_T=2).
module tb_phase_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ped_req;
    logic [7:0] lights;
    logic [3:0] grant;
    logic       ped_walk;
    logic       busy;
    int         errors;
    int         checks;

    phase_scheduler #(
        .TICK_DIV (4),
        .MIN_GREEN(2),
        .MAX_GREEN(4),
        .YELLOW_T (1),
        .ALLRED_T (1),
        .WALK_T   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ped_req (ped_req),
        .lights  (lights),
        .grant   (grant),
        .ped_walk(ped_walk),
        .busy    (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for two clocks and release it on a falling edge.
    task automatic apply_reset;
        @(negedge clk);
        rst     = 1'b1;
        req     = 4'b0000;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst     = 1'b1;
        req     = 4'b0000;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (lights !== 8'hFF) begin errors++; $display("FAIL reset_lights: got %h expected %h", lights, 8'hFF); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        checks++; if (ped_walk !== 1'b0) begin errors++; $display("FAIL reset_ped_walk: got %b expected %b", ped_walk, 1'b0); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_single_request;
        logic [7:0] exp_l;
        logic [3:0] exp_g;
        logic       exp_b;
        apply_reset();
        req = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_l = (c <= 8) ? 8'hF7 : (c <= 12) ? 8'hFB : 8'hFF;
            exp_g = (c <= 12) ? 4'b0010 : 4'b0000;
            exp_b = (c <= 16);
            checks++; if (lights !== exp_l) begin errors++; $display("FAIL single_lights c=%0d: got %h expected %h", c, lights, exp_l); end
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL single_grant c=%0d: got %b expected %b", c, grant, exp_g); end
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, exp_b); end
            req = 4'b0000;
        end
    endtask

    task automatic test_max_out;
        logic [7:0] exp_l;
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b0101;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            exp_l = (c <= 16) ? 8'hFD : (c <= 20) ? 8'hFE : (c <= 24) ? 8'hFF : 8'hDF;
            exp_g = (c <= 20) ? 4'b0001 : (c <= 24) ? 4'b0000 : 4'b0100;
            checks++; if (lights !== exp_l) begin errors++; $display("FAIL maxout_lights c=%0d: got %h expected %h", c, lights, exp_l); end
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL maxout_grant c=%0d: got %b expected %b", c, grant, exp_g); end
        end
        req = 4'b0000;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b1111;
        for (int c = 1; c <= 97; c++) begin
            @(negedge clk);
            if (((c - 1) % 24) == 0) begin
                exp_g = 4'b0001 << (((c - 1) / 24) % 4);
                checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, grant, exp_g); end
            end else if (((c - 1) % 24) == 20) begin
                checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_allred_grant c=%0d: got %b expected %b", c, grant, 4'b0000); end
            end else begin
                exp_g = 4'b0000;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_yellow;
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req = 4'b0000;
            if (c == 10) begin
                checks++; if (lights !== 8'hFE) begin errors++; $display("FAIL midyel_pre_lights: got %h expected %h", lights, 8'hFE); end
                rst = 1'b1;
            end else if (c == 11) begin
                checks++; if (lights !== 8'hFF) begin errors++; $display("FAIL midyel_lights: got %h expected %h", lights, 8'hFF); end
                checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midyel_grant: got %b expected %b", grant, 4'b0000); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midyel_busy: got %b expected %b", busy, 1'b0); end
                rst = 1'b0;
            end else if (c > 11) begin
                checks++; if ((busy !== 1'b0) || (grant !== 4'b0000)) begin errors++; $display("FAIL midyel_stay_idle c=%0d: got busy=%b grant=%b expected busy=0 grant=0000", c, busy, grant); end
            end else begin
                rst = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 12) begin
                checks++; if (lights !== 8'hFE) begin errors++; $display("FAIL b2b_yellow_lights: got %h expected %h", lights, 8'hFE); end
            end else if (c == 17) begin
                checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL b2b_same_cycle_grant: got %b expected %b", grant, 4'b0010); end
                checks++; if (lights !== 8'hF7) begin errors++; $display("FAIL b2b_e_lights: got %h expected %h", lights, 8'hF7); end
            end else if (c == 25) begin
                checks++; if (lights !== 8'hFB) begin errors++; $display("FAIL b2b_e_yellow: got %h expected %h", lights, 8'hFB); end
            end else if (c == 33) begin
                checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL b2b_latched_grant: got %b expected %b", grant, 4'b0001); end
                checks++; if (lights !== 8'hFD) begin errors++; $display("FAIL b2b_latched_lights: got %h expected %h", lights, 8'hFD); end
            end else begin
                checks = checks;
            end
            req = (c == 10) ? 4'b0001 : (c == 16) ? 4'b0010 : 4'b0000;
        end
        req = 4'b0000;
    endtask

    task automatic test_pedestrian;
        logic [7:0] exp_l;
        logic       exp_w;
        logic       exp_b;
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
`ifdef PHASE_SCHED_PED_EN
            exp_w = (c >= 17) && (c <= 24);
            exp_b = (c <= 24);
`else
            exp_w = 1'b0;
            exp_b = (c <= 16);
`endif
            exp_l = (c <= 8) ? 8'hFD : (c <= 12) ? 8'hFE : 8'hFF;
            checks++; if (ped_walk !== exp_w) begin errors++; $display("FAIL ped_walk c=%0d: got %b expected %b", c, ped_walk, exp_w); end
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL ped_busy c=%0d: got %b expected %b", c, busy, exp_b); end
            checks++; if (lights !== exp_l) begin errors++; $display("FAIL ped_lights c=%0d: got %h expected %h", c, lights, exp_l); end
            req     = 4'b0000;
            ped_req = (c == 2);
        end
        ped_req = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        req     = 4'b0000;
        ped_req = 1'b0;
        test_reset();
        test_single_request();
        test_max_out();
        test_round_robin();
        test_reset_mid_yellow();
        test_back_to_back();
        test_pedestrian();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
